// File: rtl/cpu54_pkg.sv
// Shared ISA constants for the cpu54 core: immediate extension classes plus
// the opcode/funct codes used by the control unit and the immediate stage.
package cpu54_pkg;

    typedef enum logic [2:0] {
        IMM_NONE   = 3'd0,
        IMM_SEXT16 = 3'd1,
        IMM_ZEXT16 = 3'd2,
        IMM_LUI    = 3'd3,
        IMM_SEXT18 = 3'd4,
        IMM_ZEXT5  = 3'd5,
        IMM_JUMP   = 3'd6
    } imm_kind_t;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_REGIMM  = 6'h01;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_BLEZ    = 6'h06;
    localparam logic [5:0] OP_BGTZ    = 6'h07;
    localparam logic [5:0] OP_ADDI    = 6'h08;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_SLTI    = 6'h0A;
    localparam logic [5:0] OP_SLTIU   = 6'h0B;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_XORI    = 6'h0E;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_LB      = 6'h20;
    localparam logic [5:0] OP_LH      = 6'h21;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_LBU     = 6'h24;
    localparam logic [5:0] OP_LHU     = 6'h25;
    localparam logic [5:0] OP_SB      = 6'h28;
    localparam logic [5:0] OP_SH      = 6'h29;
    localparam logic [5:0] OP_SW      = 6'h2B;

    localparam logic [5:0] FN_SLL     = 6'h00;
    localparam logic [5:0] FN_SRL     = 6'h02;
    localparam logic [5:0] FN_SRA     = 6'h03;

endpackage

// File: rtl/imm_ext_decode.sv
// Combinational classify-and-extend of one instruction word into its
// immediate class and 32-bit extended value.
module imm_ext_decode
    import cpu54_pkg::*;
(
    input  logic [31:0] instr,
    output imm_kind_t   immKind,
    output logic [31:0] immValue
);

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [15:0] imm16;

    assign opcode = instr[31:26];
    assign funct  = instr[5:0];
    assign imm16  = instr[15:0];

    always_comb begin
        immKind  = IMM_NONE;
        immValue = 32'd0;
        case (opcode)
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
            OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW,
            OP_SB, OP_SH, OP_SW: begin
                immKind  = IMM_SEXT16;
                immValue = {{16{imm16[15]}}, imm16};
            end
            OP_ANDI, OP_ORI, OP_XORI: begin
                immKind  = IMM_ZEXT16;
                immValue = {16'd0, imm16};
            end
            OP_LUI: begin
                immKind  = IMM_LUI;
                immValue = {imm16, 16'd0};
            end
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_REGIMM: begin
                immKind  = IMM_SEXT18;
                immValue = {{14{imm16[15]}}, imm16, 2'b00};
            end
            OP_J, OP_JAL: begin
                // Upper PC nibble is merged in EX; only the word offset is formed here.
                immKind  = IMM_JUMP;
                immValue = {4'd0, instr[25:0], 2'b00};
            end
            OP_SPECIAL: begin
                if (funct == FN_SLL || funct == FN_SRL || funct == FN_SRA) begin
                    immKind  = IMM_ZEXT5;
                    immValue = {27'd0, instr[10:6]};
                end
            end
            default: begin
                immKind  = IMM_NONE;
                immValue = 32'd0;
            end
        endcase
    end

endmodule

// File: rtl/imm_ext_stage.sv
// ID/EX immediate stage: decodes the immediate and registers it toward EX
// through a main entry plus one skid entry so id_ready stays a register.
module imm_ext_stage
    import cpu54_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        id_valid,
    output logic        id_ready,
    input  logic        flush,
    input  logic        ex_ready,
    output logic        ex_valid,
    output logic [31:0] imm_out,
    output logic [2:0]  imm_kind
);

    imm_kind_t   decKind;
    logic [31:0] decImm;

    imm_ext_decode uDecode (
        .instr    (instr),
        .immKind  (decKind),
        .immValue (decImm)
    );

    logic        mValid, mValidNext;
    imm_kind_t   mKind, mKindNext;
    logic [31:0] mImm, mImmNext;
    logic        sValid, sValidNext;
    imm_kind_t   sKind, sKindNext;
    logic [31:0] sImm, sImmNext;
    logic        idReadyReg;
    logic        accept;

    assign accept = id_valid && idReadyReg;

    always_comb begin
        mValidNext = mValid;
        mKindNext  = mKind;
        mImmNext   = mImm;
        sValidNext = sValid;
        sKindNext  = sKind;
        sImmNext   = sImm;
        if (flush) begin
            mValidNext = 1'b0;
            sValidNext = 1'b0;
        end else if (!mValid || ex_ready) begin
            if (sValid) begin
                // Skid entry is older than anything arriving now, so it advances first.
                mValidNext = 1'b1;
                mKindNext  = sKind;
                mImmNext   = sImm;
                sValidNext = accept;
                if (accept) begin
                    sKindNext = decKind;
                    sImmNext  = decImm;
                end
            end else begin
                mValidNext = accept;
                sValidNext = 1'b0;
                if (accept) begin
                    mKindNext = decKind;
                    mImmNext  = decImm;
                end
            end
        end else if (accept) begin
            sValidNext = 1'b1;
            sKindNext  = decKind;
            sImmNext   = decImm;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mValid     <= 1'b0;
            mKind      <= IMM_NONE;
            mImm       <= 32'd0;
            sValid     <= 1'b0;
            sKind      <= IMM_NONE;
            sImm       <= 32'd0;
            idReadyReg <= 1'b1;
        end else begin
            mValid     <= mValidNext;
            mKind      <= mKindNext;
            mImm       <= mImmNext;
            sValid     <= sValidNext;
            sKind      <= sKindNext;
            sImm       <= sImmNext;
            idReadyReg <= !sValidNext;
        end
    end

    assign id_ready = idReadyReg;
    assign ex_valid = mValid;
    assign imm_out  = mImm;
    assign imm_kind = mKind;

endmodule

// File: tb/tb_imm_ext_stage.sv
// Self-checking bench for imm_ext_stage: directed scenarios plus a randomized
// run against a two-deep FIFO reference model with arithmetic immediate rules.
module tb_imm_ext_stage;

    logic        clk;
    logic        rst_n;
    logic [31:0] instr;
    logic        idValid;
    logic        idReady;
    logic        flush;
    logic        exReady;
    logic        exValid;
    logic [31:0] immOut;
    logic [2:0]  immKind;

    int passCnt  = 0;
    int totalCnt = 0;

    // Each model entry is {kind[2:0], imm[31:0]}; q[0] is the beat EX sees.
    logic [34:0] q[$];

    imm_ext_stage dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .instr    (instr),
        .id_valid (idValid),
        .id_ready (idReady),
        .flush    (flush),
        .ex_ready (exReady),
        .ex_valid (exValid),
        .imm_out  (immOut),
        .imm_kind (immKind)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [34:0] refDecode(input logic [31:0] w);
        int unsigned op  = w[31:26];
        int unsigned fn  = w[5:0];
        int unsigned u16 = w[15:0];
        longint      s16 = (u16 >= 32768) ? longint'(u16) - 65536 : longint'(u16);
        logic [31:0] v   = 32'd0;
        logic [2:0]  k   = 3'd0;
        if (op inside {8, 9, 10, 11, 32, 33, 35, 36, 37, 40, 41, 43}) begin
            k = 3'd1; v = 32'(s16);
        end else if (op inside {12, 13, 14}) begin
            k = 3'd2; v = u16;
        end else if (op == 15) begin
            k = 3'd3; v = u16 * 65536;
        end else if (op inside {1, 4, 5, 6, 7}) begin
            k = 3'd4; v = 32'(s16 * 4);
        end else if (op == 0 && fn inside {0, 2, 3}) begin
            k = 3'd5; v = (w / 64) % 32;
        end else if (op inside {2, 3}) begin
            k = 3'd6; v = (w % (32'd1 << 26)) * 4;
        end
        return {k, v};
    endfunction

    function automatic logic [31:0] randInstr();
        int unsigned ops[28] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15,
                                 32, 33, 35, 36, 37, 40, 41, 43, 16, 17, 34, 63};
        int unsigned fns[5]  = '{0, 2, 3, 8, 32};
        logic [31:0] w;
        logic [5:0]  op;
        op = 6'(ops[$urandom_range(0, 27)]);
        w  = {op, 26'($urandom)};
        if (op == 6'd0) w[5:0] = 6'(fns[$urandom_range(0, 4)]);
        return w;
    endfunction

    // Applies one cycle of stimulus and advances the reference model at the edge.
    task automatic drive(input logic v, input logic [31:0] ins, input logic er, input logic fl);
        logic acc;
        idValid = v;
        instr   = ins;
        exReady = er;
        flush   = fl;
        acc = v && (q.size() < 2);
        @(posedge clk);
        if (fl) begin
            q.delete();
        end else begin
            if (er && q.size() > 0) void'(q.pop_front());
            if (acc) q.push_back(refDecode(ins));
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; idValid = 1'b0; instr = 32'd0; exReady = 1'b0; flush = 1'b0;
        q.delete();
        repeat (2) @(posedge clk);
        #1;
        totalCnt++;
        if (exValid !== 1'b0 || immOut !== 32'd0 || immKind !== 3'd0)
            $display("FAIL reset_outputs got v=%0b imm=%h kind=%0d want v=0 imm=00000000 kind=0",
                     exValid, immOut, immKind);
        else passCnt++;
        totalCnt++;
        if (idReady !== 1'b1) $display("FAIL reset_ready got %0b want 1", idReady);
        else passCnt++;
        rst_n = 1'b1;
        @(posedge clk); #1;
        totalCnt++;
        if (exValid !== 1'b0 || idReady !== 1'b1)
            $display("FAIL post_reset_idle got v=%0b rdy=%0b want v=0 rdy=1", exValid, idReady);
        else passCnt++;
    endtask

    task automatic test_decode_back_to_back();
        logic [31:0] ins[6]  = '{32'h2128FFFC, 32'h35088000, 32'h3C081234,
                                 32'h1109FFFF, 32'h00094140, 32'h08000010};
        logic [31:0] want[6] = '{32'hFFFFFFFC, 32'h00008000, 32'h12340000,
                                 32'hFFFFFFFC, 32'h00000005, 32'h00000040};
        logic [2:0]  kind[6] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6};
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, ins[i], 1'b1, 1'b0);
            totalCnt++;
            if (exValid !== 1'b1 || immOut !== want[i] || immKind !== kind[i])
                $display("FAIL decode_%0d got v=%0b imm=%h kind=%0d want v=1 imm=%h kind=%0d",
                         i, exValid, immOut, immKind, want[i], kind[i]);
            else passCnt++;
        end
        drive(1'b0, 32'd0, 1'b1, 1'b0);
        totalCnt++;
        if (exValid !== 1'b0) $display("FAIL decode_drain got v=%0b want 0", exValid);
        else passCnt++;
    endtask

    task automatic test_backpressure();
        logic [31:0] a = 32'h2128FFFC;
        logic [31:0] b = 32'h35088000;
        logic [31:0] c = 32'h3C081234;
        logic [31:0] seen[$];
        drive(1'b1, a, 1'b0, 1'b0);
        drive(1'b1, b, 1'b0, 1'b0);
        totalCnt++;
        if (idReady !== 1'b0 || exValid !== 1'b1 || immOut !== 32'hFFFFFFFC)
            $display("FAIL bp_full got rdy=%0b v=%0b imm=%h want rdy=0 v=1 imm=fffffffc",
                     idReady, exValid, immOut);
        else passCnt++;
        drive(1'b1, c, 1'b0, 1'b0);
        totalCnt++;
        if (idReady !== 1'b0 || immOut !== 32'hFFFFFFFC)
            $display("FAIL bp_hold got rdy=%0b imm=%h want rdy=0 imm=fffffffc", idReady, immOut);
        else passCnt++;
        // Keep offering the third beat until the stage takes it, recording each head consumed.
        seen.push_back(immOut);
        drive(1'b1, c, 1'b1, 1'b0);
        seen.push_back(immOut);
        drive(1'b1, c, 1'b1, 1'b0);
        seen.push_back(immOut);
        drive(1'b0, 32'd0, 1'b1, 1'b0);
        totalCnt++;
        if (seen.size() != 3 || seen[0] !== 32'hFFFFFFFC || seen[1] !== 32'h00008000 ||
            seen[2] !== 32'h12340000)
            $display("FAIL bp_order got %h %h %h want fffffffc 00008000 12340000",
                     seen[0], seen[1], seen[2]);
        else passCnt++;
        totalCnt++;
        if (exValid !== 1'b0 || idReady !== 1'b1)
            $display("FAIL bp_empty got v=%0b rdy=%0b want v=0 rdy=1", exValid, idReady);
        else passCnt++;
    endtask

    task automatic test_flush();
        int stray = 0;
        drive(1'b1, 32'h2128FFFC, 1'b0, 1'b0);
        drive(1'b1, 32'h35088000, 1'b0, 1'b0);
        drive(1'b1, 32'h3C081234, 1'b0, 1'b1);
        totalCnt++;
        if (exValid !== 1'b0 || idReady !== 1'b1)
            $display("FAIL flush_clear got v=%0b rdy=%0b want v=0 rdy=1", exValid, idReady);
        else passCnt++;
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 32'd0, 1'b1, 1'b0);
            if (exValid !== 1'b0) stray++;
        end
        totalCnt++;
        if (stray != 0) $display("FAIL flush_stray got %0d beats want 0", stray);
        else passCnt++;
        // Flush coinciding with consumption leaves nothing behind.
        drive(1'b1, 32'h08000010, 1'b1, 1'b0);
        drive(1'b1, 32'h1109FFFF, 1'b1, 1'b1);
        totalCnt++;
        if (exValid !== 1'b0) $display("FAIL flush_with_ready got v=%0b want 0", exValid);
        else passCnt++;
    endtask

    task automatic test_async_reset();
        drive(1'b1, 32'h2128FFFC, 1'b0, 1'b0);
        drive(1'b1, 32'h35088000, 1'b0, 1'b0);
        totalCnt++;
        if (exValid !== 1'b1 || idReady !== 1'b0)
            $display("FAIL areset_pre got v=%0b rdy=%0b want v=1 rdy=0", exValid, idReady);
        else passCnt++;
        #2;
        rst_n = 1'b0;
        idValid = 1'b0;
        #1;
        q.delete();
        totalCnt++;
        if (exValid !== 1'b0 || immOut !== 32'd0 || immKind !== 3'd0 || idReady !== 1'b1)
            $display("FAIL areset_clear got v=%0b imm=%h kind=%0d rdy=%0b want 0 00000000 0 1",
                     exValid, immOut, immKind, idReady);
        else passCnt++;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1'b0, 32'd0, 1'b1, 1'b0);
        totalCnt++;
        if (exValid !== 1'b0) $display("FAIL areset_ghost got v=%0b want 0", exValid);
        else passCnt++;
        drive(1'b1, 32'h00094140, 1'b1, 1'b0);
        totalCnt++;
        if (exValid !== 1'b1 || immOut !== 32'h00000005 || immKind !== 3'd5)
            $display("FAIL areset_first got v=%0b imm=%h kind=%0d want 1 00000005 5",
                     exValid, immOut, immKind);
        else passCnt++;
        drive(1'b0, 32'd0, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        logic        wantReady;
        logic        wantValid;
        logic [34:0] got;
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 3) != 0, randInstr(), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 31) == 0);
            wantReady = (q.size() < 2);
            wantValid = (q.size() > 0);
            totalCnt++;
            if (idReady !== wantReady)
                $display("FAIL rand_ready cyc=%0d got %0b want %0b", i, idReady, wantReady);
            else passCnt++;
            totalCnt++;
            if (exValid !== wantValid)
                $display("FAIL rand_valid cyc=%0d got %0b want %0b", i, exValid, wantValid);
            else passCnt++;
            if (q.size() > 0) begin
                got = {immKind, immOut};
                totalCnt++;
                if (got !== q[0])
                    $display("FAIL rand_head cyc=%0d got kind=%0d imm=%h want kind=%0d imm=%h",
                             i, got[34:32], got[31:0], q[0][34:32], q[0][31:0]);
                else passCnt++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_decode_back_to_back();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule

// File: doc/imm_ext_stage.md
# imm_ext_stage

Decode-to-execute immediate stage for the 54-instruction pipelined MIPS core. It classifies each decoded instruction's immediate field, performs the matching extension and registers the result toward EX behind a valid/ready handshake. A two-entry skid buffer keeps `id_ready` a pure register output. It replaces ad-hoc extender selection in the ID/EX boundary and is the single owner of immediate formation.

## Interface
- No parameters; widths are fixed by the ISA (32-bit instruction, 32-bit immediate).
- `clk` in 1 — single clock, rising edge.
- `rst_n` in 1 — asynchronous, active-low reset.
- `instr` in 32 — instruction word from ID.
- `id_valid` in 1 — `instr` is valid this cycle.
- `id_ready` out 1 — stage can accept; registered.
- `flush` in 1 — kill all held and incoming beats (branch/exception redirect).
- `ex_ready` in 1 — EX consumes the head beat.
- `ex_valid` out 1 — `imm_out`/`imm_kind` are valid.
- `imm_out` out 32 — extended immediate.
- `imm_kind` out 3 — extension class: NONE, SEXT16, ZEXT16, LUI, SEXT18, ZEXT5, JUMP.

## Operation
- Classification by opcode `instr[31:26]` (funct `instr[5:0]` for opcode 0):
  - SEXT16: addi, addiu, slti, sltiu, lb, lbu, lh, lhu, lw, sb, sh, sw → `{{16{i[15]}}, i[15:0]}`.
  - ZEXT16: andi, ori, xori → `{16'b0, i[15:0]}`.
  - LUI: lui → `{i[15:0], 16'b0}`.
  - SEXT18: beq, bne, blez, bgtz, REGIMM (bltz/bgez) → `{{14{i[15]}}, i[15:0], 2'b0}`.
  - ZEXT5: opcode 0 with funct sll/srl/sra → `{27'b0, i[10:6]}`.
  - JUMP: j, jal → `{4'b0, i[25:0], 2'b0}`; EX merges PC[31:28].
  - Everything else: NONE, `imm_out = 0`.
- Storage: main entry M (drives outputs) and skid entry S; each holds a valid bit, kind and immediate.
- Accept when `id_valid && id_ready`.
- Per-cycle update (flush has highest priority):
  - `flush`: M.v ← 0, S.v ← 0; the beat presented this cycle is dropped.
  - Else, if M empty or `ex_ready`: M ← S if S.v, else the accepted beat. If S was moved, the accepted beat goes to S; otherwise S.v ← 0.
  - Else (M held, stalled): the accepted beat goes to S.
- `id_ready` ← !S.v next state; accept is never possible while S is full.
- Ordering is strict FIFO; no beat is duplicated or lost except by `flush`.

## Timing
- Reset (asynchronous, immediate): `ex_valid` 0, `imm_out` 0, `imm_kind` NONE, `id_ready` 1, S.v 0.
- Latency is one cycle from accept to `ex_valid` when M is empty or draining; decode is combinational before the register.
- Throughput is one beat per cycle when `ex_ready` is held high.
- `id_ready` drops the cycle after S fills. It rises the cycle after S drains or after a flush.
- `flush` with `ex_ready` in the same cycle: the head beat counts as consumed by EX, and nothing remains.
- Reset asserted mid-stall clears both entries; no beat reappears after release.
- Outputs are registered only; there is no combinational path from `instr` to `imm_out`.

## Structure
- `cpu54_pkg`: `imm_kind_t` enum (3-bit encoding NONE=0 … JUMP=6), opcode and funct constants shared with the control unit.
- Sub-module `imm_ext_decode`: combinational classify-and-extend of `instr` → {kind, imm}.
- The top level holds the M/S skid registers and the handshake.

## Test plan
- addi 0x2128FFFC with `ex_ready`=1 → next cycle `ex_valid`=1, `imm_out`=0xFFFFFFFC, kind SEXT16.
- ori 0x35088000 then lui 0x3C081234 back-to-back → 0x00008000 ZEXT16, then 0x12340000 LUI on consecutive cycles.
- beq 0x1109FFFF → 0xFFFFFFFC SEXT18. sll 0x00094140 → 0x00000005 ZEXT5. j 0x08000010 → 0x00000040 JUMP.
- Backpressure: `ex_ready`=0, three beats offered:
  - first two are accepted and `id_ready` falls;
  - the third is held off;
  - after `ex_ready`=1 all three appear in order, with no duplicates.
- Flush with M and S full and `id_valid`=1 → next cycle `ex_valid`=0, `id_ready`=1; none of the three beats ever appears.
- Assert `rst_n`=0 asynchronously mid-stall → outputs clear before the next edge; after release the first new beat appears with one-cycle latency.
